// File: rtl/uart_rx_pkg.sv
// Shared UART receiver definitions: FSM encodings, frame constants and the
// bit-period derivation used by the receiver (and reusable by a transmitter).
package uart_rx_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

  function automatic int clks_per_bit(input int sys_clock, input int baud_rate);
    return sys_clock / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to 1 so an
// idle line is seen during and just after reset.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [1:0] sync_ff;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_ff <= 2'b11;
    end else begin
      sync_ff <= {sync_ff[0], d};
    end
  end

  assign q = sync_ff[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling of a synchronised line, one-cycle
// data_valid / framing_error strobes, and break hold after a bad stop bit.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int SYS_CLOCK = 1000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_input,
  output logic [7:0] data_output,
  output logic       data_valid,
  output logic       framing_error,
  output logic       busy,
  output logic [2:0] debug_state
);

  localparam int CPB   = clks_per_bit(SYS_CLOCK, BAUD_RATE);
  localparam int CNT_W = $clog2(CPB);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'((CPB - 1) / 2);
  localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

  rx_state_t        state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             rx;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx_input),
    .q     (rx)
  );

  // Output handshake: valid-only, no ready. data_valid is high for exactly one
  // cycle when data_output takes a new good byte; the consumer must capture it
  // in that cycle. framing_error is a separate one-cycle strobe, never coincident.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      clk_cnt       <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      data_output   <= '0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
      busy          <= 1'b0;
    end else begin
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
      case (state)
        ST_IDLE: begin
          busy <= 1'b0;
          if (!rx) begin
            state   <= ST_START;
            clk_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        ST_START: begin
          if (clk_cnt == CNT_MID) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            if (!rx) begin
              state <= ST_DATA;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          // Counting a full bit period from the start-bit midpoint lands mid-bit.
          if (clk_cnt == CNT_LAST) begin
            shreg[bit_cnt] <= rx;
            clk_cnt        <= '0;
            if (bit_cnt == BIT_LAST) begin
              state <= ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            if (rx) begin
              data_output <= shreg;
              data_valid  <= 1'b1;
              state       <= ST_IDLE;
              busy        <= 1'b0;
            end else begin
              framing_error <= 1'b1;
              state         <= ST_BREAK;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        ST_BREAK: begin
          // Wait out a held-low line so it is not mistaken for a new start bit.
          if (rx) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign debug_state = state;

endmodule
